// File: rtl/capture_ctrl_if.sv
// Signal bundle for capture_ctrl: ADC sample input, trigger configuration,
// FIFO pointer controls and the host readout stream.
interface capture_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_SIZE  = 8
);
    logic                  arm_i;
    logic                  abort_i;
    logic [DATA_WIDTH-1:0] sample_i;
    logic                  sample_vld_i;
    logic [DATA_WIDTH-1:0] trig_level_i;
    logic                  trig_rising_i;
    logic [ADDR_SIZE:0]    post_cnt_i;
    logic                  fifo_full_i;
    logic                  fifo_empty_i;
    logic [DATA_WIDTH-1:0] fifo_rdata_i;
    logic                  fifo_wr_o;
    logic [DATA_WIDTH-1:0] fifo_wdata_o;
    logic                  fifo_rd_o;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_vld_o;
    logic                  out_rdy_i;
    logic [1:0]            state_o;
    logic                  done_o;
    logic                  ovf_o;
    logic                  auto_trig_o;

    modport slave (
        input  arm_i, abort_i, sample_i, sample_vld_i, trig_level_i, trig_rising_i,
        input  post_cnt_i, fifo_full_i, fifo_empty_i, fifo_rdata_i, out_rdy_i,
        output fifo_wr_o, fifo_wdata_o, fifo_rd_o, out_data_o, out_vld_o,
        output state_o, done_o, ovf_o, auto_trig_o
    );

    modport master (
        output arm_i, abort_i, sample_i, sample_vld_i, trig_level_i, trig_rising_i,
        output post_cnt_i, fifo_full_i, fifo_empty_i, fifo_rdata_i, out_rdy_i,
        input  fifo_wr_o, fifo_wdata_o, fifo_rd_o, out_data_o, out_vld_o,
        input  state_o, done_o, ovf_o, auto_trig_o
    );
endinterface

// File: rtl/capture_ctrl.sv
// Oscilloscope acquisition sequencer: pre-trigger ring, trigger, post-trigger fill, drain.
// Optional forced trigger after AUTO_SAMPLES armed samples when CAPTURE_AUTO_TRIG_EN is defined.
module capture_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_SIZE    = 8,
    parameter int unsigned AUTO_SAMPLES = 1024
) (
    input logic           clk_i,
    input logic           rst_i,
    capture_ctrl_if.slave bus
);
    localparam int unsigned CntW = ADDR_SIZE + 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StPost  = 2'd2,
        StDrain = 2'd3
    } state_e;

    if (AUTO_SAMPLES < 1) begin : g_auto_chk
        $error("AUTO_SAMPLES must be at least 1");
    end

    state_e                r_state;
    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_prev_vld;
    logic [CntW-1:0]       r_post_cnt;
    logic                  r_done;
    logic                  r_ovf;

    logic w_rise;
    logic w_fall;
    logic w_real_trig;
    logic w_force_trig;
    logic w_trig;
    logic w_wr;
    logic w_rd;
    logic w_out_vld;

    always_comb begin
        w_rise      = (r_prev < bus.trig_level_i) && (bus.sample_i >= bus.trig_level_i);
        w_fall      = (r_prev > bus.trig_level_i) && (bus.sample_i <= bus.trig_level_i);
        w_real_trig = bus.sample_vld_i && r_prev_vld && (bus.trig_rising_i ? w_rise : w_fall);
    end

`ifdef CAPTURE_AUTO_TRIG_EN
    localparam int unsigned AutoW = $clog2(AUTO_SAMPLES + 1);

    logic [AutoW-1:0] r_auto_cnt;
    logic             r_auto;

    // A real trigger on the same sample takes precedence over the forced one.
    assign w_force_trig = bus.sample_vld_i && !w_real_trig &&
                          (r_auto_cnt == AutoW'(AUTO_SAMPLES - 1));
    assign bus.auto_trig_o = r_auto;
`else
    assign w_force_trig    = 1'b0;
    assign bus.auto_trig_o = 1'b0;
`endif

    assign w_trig = w_real_trig || w_force_trig;

    always_comb begin
        w_wr      = 1'b0;
        w_rd      = 1'b0;
        w_out_vld = 1'b0;
        if (!bus.abort_i) begin
            case (r_state)
                StIdle: ;
                StArmed: begin
                    // Ring mode: a write into a full FIFO also retires the oldest word.
                    w_wr = bus.sample_vld_i;
                    w_rd = bus.sample_vld_i && bus.fifo_full_i;
                end
                StPost: begin
                    w_wr = bus.sample_vld_i && !bus.fifo_full_i;
                end
                StDrain: begin
                    w_out_vld = !bus.fifo_empty_i;
                    w_rd      = w_out_vld && bus.out_rdy_i;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= StIdle;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_post_cnt <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
            r_auto_cnt <= '0;
            r_auto     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (bus.abort_i) begin
                r_state <= StIdle;
            end else begin
                case (r_state)
                    StIdle: begin
                        // Flags stay readable after done/abort until the next arm.
                        if (bus.arm_i) begin
                            r_state    <= StArmed;
                            r_prev_vld <= 1'b0;
                            r_ovf      <= 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
                            r_auto_cnt <= '0;
                            r_auto     <= 1'b0;
`endif
                        end
                    end
                    StArmed: begin
                        if (bus.sample_vld_i) begin
                            r_prev     <= bus.sample_i;
                            r_prev_vld <= 1'b1;
`ifdef CAPTURE_AUTO_TRIG_EN
                            r_auto_cnt <= r_auto_cnt + 1'b1;
`endif
                            if (w_trig) begin
                                r_post_cnt <= bus.post_cnt_i;
                                r_state    <= (bus.post_cnt_i == '0) ? StDrain : StPost;
`ifdef CAPTURE_AUTO_TRIG_EN
                                r_auto     <= w_force_trig;
`endif
                            end
                        end
                    end
                    StPost: begin
                        if (bus.sample_vld_i) begin
                            if (bus.fifo_full_i) begin
                                r_ovf   <= 1'b1;
                                r_state <= StDrain;
                            end else begin
                                r_post_cnt <= r_post_cnt - 1'b1;
                                if (r_post_cnt == CntW'(1)) begin
                                    r_state <= StDrain;
                                end
                            end
                        end
                    end
                    StDrain: begin
                        if (bus.fifo_empty_i) begin
                            r_state <= StIdle;
                            r_done  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.fifo_wdata_o = bus.sample_i;
    assign bus.fifo_wr_o    = w_wr;
    assign bus.fifo_rd_o    = w_rd;
    assign bus.out_vld_o    = w_out_vld;
    assign bus.out_data_o   = bus.fifo_rdata_i;
    assign bus.state_o      = r_state;
    assign bus.done_o       = r_done;
    assign bus.ovf_o        = r_ovf;
endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: FWFT FIFO model, directed table and corner sequences,
// plus random captures checked against a capture-level reference model.
module tb_capture_ctrl;
    localparam int DW    = 8;
    localparam int AS    = 4;
    localparam int DEPTH = 16;
    localparam int AUTO  = 8;
`ifdef CAPTURE_AUTO_TRIG_EN
    localparam bit AUTO_ON = 1'b1;
`else
    localparam bit AUTO_ON = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    capture_ctrl_if #(.DATA_WIDTH(DW), .ADDR_SIZE(AS)) bus ();

    capture_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_SIZE   (AS),
        .AUTO_SAMPLES(AUTO)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // FWFT FIFO model; handshakes captured mid-cycle, applied on the edge.
    logic [DW-1:0] fq[$];
    logic          m_wr = 1'b0;
    logic          m_rd = 1'b0;
    logic [DW-1:0] m_wd = '0;
    logic          flush_req = 1'b0;

    always @(negedge clk_i) begin
        m_wr = bus.fifo_wr_o;
        m_rd = bus.fifo_rd_o;
        m_wd = bus.fifo_wdata_o;
    end

    always @(posedge clk_i) begin
        int n;
        if (flush_req) begin
            fq.delete();
        end else begin
            n = fq.size();
            if (m_rd && n > 0) void'(fq.pop_front());
            if (m_wr && (n < DEPTH || m_rd)) fq.push_back(m_wd);
        end
        bus.fifo_full_i  <= (fq.size() == DEPTH);
        bus.fifo_empty_i <= (fq.size() == 0);
        bus.fifo_rdata_i <= (fq.size() > 0) ? fq[0] : '0;
    end

    typedef struct {
        bit            vld;
        logic [DW-1:0] smp;
        bit            rdy;
        logic [1:0]    st;
        bit            wr;
        bit            rd;
        bit            ovld;
        logic [DW-1:0] data;
        bit            done;
    } vec_t;

    vec_t          tbl[15];
    logic [DW-1:0] rs[128];
    bit            rv[128];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    int            dones;
    bit            ovf_seen;
    bit            auto_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic flush();
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
    endtask

    task automatic arm(input int lvl, input bit rising, input int post);
        bus.trig_level_i  = DW'(lvl);
        bus.trig_rising_i = rising;
        bus.post_cnt_i    = (AS + 1)'(post);
        bus.arm_i         = 1'b1;
        cyc();
        bus.arm_i = 1'b0;
    endtask

    task automatic put(input int s);
        bus.sample_vld_i = 1'b1;
        bus.sample_i     = DW'(s);
        cyc();
        bus.sample_vld_i = 1'b0;
    endtask

    // Streams rs/rv for n_stream cycles, then idles; collects readout words until done.
    task automatic run(input int n_stream, input int rdy_mode, input bit chk_rd, input int budget);
        int tail;
        bit ev;
        tail = -1;
        got_q.delete();
        dones = 0;
        for (int c = 0; c < budget && tail != 0; c++) begin
            bus.sample_vld_i = (c < n_stream) ? rv[c] : 1'b0;
            bus.sample_i     = (c < n_stream) ? rs[c] : '0;
            case (rdy_mode)
                0:       bus.out_rdy_i = 1'b1;
                1:       bus.out_rdy_i = (c % 2 == 0);
                default: bus.out_rdy_i = 1'($urandom % 2);
            endcase
            @(negedge clk_i);
            if (chk_rd) begin
                ev = (fq.size() != 0) && (dones == 0);
                chk("drain_vld_rd", {bus.out_vld_o, bus.fifo_rd_o}, {ev, ev && bus.out_rdy_i});
            end
            if (bus.out_vld_o && bus.out_rdy_i) got_q.push_back(bus.out_data_o);
            if (bus.done_o) begin
                dones++;
                ovf_seen  = bus.ovf_o;
                auto_seen = bus.auto_trig_o;
                if (tail < 0) tail = 3;
            end
            if (tail > 0) tail--;
            cyc();
        end
        bus.sample_vld_i = 1'b0;
        bus.out_rdy_i    = 1'b0;
    endtask

    task automatic cmp_words(input string name);
        int good;
        good = 0;
        chk({name, "_count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            if (got_q[k] === exp_q[k]) good++;
        end
        chk({name, "_data"}, good, exp_q.size());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.arm_i = 1'b0; bus.abort_i = 1'b0; bus.sample_vld_i = 1'b0; bus.sample_i = '0;
        bus.trig_level_i = '0; bus.trig_rising_i = 1'b1; bus.post_cnt_i = '0;
        bus.out_rdy_i = 1'b0;

        tbl[0]  = '{1'b1, 8'd90,  1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0};
        tbl[1]  = '{1'b1, 8'd110, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0};
        tbl[2]  = '{1'b0, 8'd0,   1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0};
        tbl[3]  = '{1'b1, 8'd5,   1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0};
        tbl[4]  = '{1'b1, 8'd6,   1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0};
        tbl[5]  = '{1'b1, 8'd7,   1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0};
        tbl[6]  = '{1'b0, 8'd0,   1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 8'd90,  1'b0};
        tbl[7]  = '{1'b0, 8'd0,   1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 8'd90,  1'b0};
        tbl[8]  = '{1'b1, 8'd99,  1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 8'd110, 1'b0};
        tbl[9]  = '{1'b0, 8'd0,   1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 8'd5,   1'b0};
        tbl[10] = '{1'b0, 8'd0,   1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 8'd6,   1'b0};
        tbl[11] = '{1'b0, 8'd0,   1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 8'd7,   1'b0};
        tbl[12] = '{1'b0, 8'd0,   1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0};
        tbl[13] = '{1'b0, 8'd0,   1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b1};
        tbl[14] = '{1'b0, 8'd0,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0};

        // Reset state
        cyc(); cyc(); cyc();
        @(negedge clk_i);
        chk("reset_outputs", {bus.state_o, bus.fifo_wr_o, bus.fifo_rd_o, bus.out_vld_o,
                              bus.done_o, bus.ovf_o, bus.auto_trig_o}, 32'd0);
        cyc();
        rst_i = 1'b1;
        cyc();

        // Rising trigger at 100, three post samples, drain with ignored sample
        flush();
        arm(100, 1'b1, 3);
        for (int i = 0; i < 15; i++) begin
            bus.sample_vld_i = tbl[i].vld;
            bus.sample_i     = tbl[i].smp;
            bus.out_rdy_i    = tbl[i].rdy;
            @(negedge clk_i);
            chk($sformatf("table_row%0d", i),
                {bus.state_o, bus.fifo_wr_o, bus.fifo_rd_o, bus.out_vld_o, bus.done_o,
                 bus.out_vld_o ? bus.out_data_o : 8'h00},
                {tbl[i].st, tbl[i].wr, tbl[i].rd, tbl[i].ovld, tbl[i].done,
                 tbl[i].ovld ? tbl[i].data : 8'h00});
            cyc();
        end
        bus.sample_vld_i = 1'b0;
        bus.out_rdy_i    = 1'b0;

        // Ramp fills the ring, then a post_cnt=0 trigger goes straight to DRAIN
        flush();
        arm(200, 1'b1, 0);
        for (int i = 0; i < 40; i++) begin
            bus.sample_vld_i = 1'b1;
            bus.sample_i     = DW'(i);
            @(negedge clk_i);
            chk($sformatf("ramp_%0d", i), {bus.fifo_wr_o, bus.fifo_rd_o, bus.state_o},
                {1'b1, (i >= 16), 2'd1});
            cyc();
        end
        bus.sample_i = 8'd250;
        @(negedge clk_i);
        chk("trig_full_wr_rd", {bus.fifo_wr_o, bus.fifo_rd_o}, 2'b11);
        cyc();
        bus.sample_vld_i = 1'b0;
        @(negedge clk_i);
        chk("post0_to_drain", bus.state_o, 2'd3);
        cyc();
        run(0, 1, 1'b1, 80);
        exp_q.delete();
        for (int v = 25; v < 40; v++) exp_q.push_back(DW'(v));
        exp_q.push_back(8'd250);
        cmp_words("toggle_drain");
        chk("toggle_done_once", dones, 1);

        // post_cnt beyond depth ends on overflow, then reset mid-DRAIN
        flush();
        arm(100, 1'b1, 20);
        put(0);
        put(150);
        for (int i = 1; i <= 14; i++) put(i);
        bus.sample_vld_i = 1'b1;
        bus.sample_i     = 8'd77;
        @(negedge clk_i);
        chk("ovf_drop_no_wr", {bus.fifo_wr_o, bus.ovf_o, bus.state_o}, {1'b0, 1'b0, 2'd2});
        cyc();
        bus.sample_vld_i = 1'b0;
        @(negedge clk_i);
        chk("ovf_set_drain", {bus.ovf_o, bus.state_o, bus.out_vld_o}, {1'b1, 2'd3, 1'b1});
        rst_i = 1'b0;
        #1;
        chk("reset_mid_drain", {bus.state_o, bus.out_vld_o, bus.done_o, bus.ovf_o}, 32'd0);
        cyc();
        rst_i = 1'b1;
        flush();

        // Abort while in POST
        arm(100, 1'b1, 5);
        put(0);
        put(150);
        put(3);
        bus.abort_i      = 1'b1;
        bus.sample_vld_i = 1'b1;
        bus.sample_i     = 8'd4;
        @(negedge clk_i);
        chk("abort_post_no_wr", {bus.state_o, bus.fifo_wr_o}, {2'd2, 1'b0});
        cyc();
        bus.abort_i      = 1'b0;
        bus.sample_vld_i = 1'b0;
        @(negedge clk_i);
        chk("abort_to_idle", bus.state_o, 2'd0);
        cyc();
        flush();

        // Flat input below level: forced trigger only when the auto feature is built
        arm(100, 1'b1, 2);
        for (int i = 0; i < 8; i++) put(50);
        @(negedge clk_i);
        chk("auto_after8", {bus.state_o, bus.auto_trig_o},
            AUTO_ON ? {2'd2, 1'b1} : {2'd1, 1'b0});
        cyc();
        if (AUTO_ON) begin
            rs[0] = 8'd50; rv[0] = 1'b1;
            rs[1] = 8'd50; rv[1] = 1'b1;
            run(2, 0, 1'b0, 60);
            exp_q.delete();
            for (int i = 0; i < 10; i++) exp_q.push_back(8'd50);
            cmp_words("auto_drain");
            chk("auto_flag_at_done", {dones[1:0], auto_seen}, {2'd1, 1'b1});
        end else begin
            bus.abort_i = 1'b1;
            cyc();
            bus.abort_i = 1'b0;
        end
        flush();

        // Random captures against the capture-level model
        for (int trial = 0; trial < 40; trial++) begin
            int lvl, post, trig, lo, n_left;
            bit rising, forced, complete, ovf_e, real_t;
            int st_e;
            logic [DW-1:0] vs[$];
            lvl    = $urandom_range(30, 225);
            rising = 1'($urandom % 2);
            post   = $urandom_range(0, 20);
            vs.delete();
            for (int e = 0; e < 120; e++) begin
                rs[e] = DW'($urandom_range(0, 255));
                rv[e] = ($urandom % 4) != 0;
                if (rv[e]) vs.push_back(rs[e]);
            end
            trig = -1;
            forced = 1'b0;
            for (int j = 0; j < vs.size(); j++) begin
                real_t = 1'b0;
                if (j > 0) real_t = rising ? (vs[j-1] < lvl && vs[j] >= lvl)
                                           : (vs[j-1] > lvl && vs[j] <= lvl);
                if (real_t) begin
                    trig = j;
                    break;
                end
                if (AUTO_ON && j == AUTO - 1) begin
                    trig = j;
                    forced = 1'b1;
                    break;
                end
            end
            exp_q.delete();
            ovf_e = 1'b0;
            complete = 1'b0;
            st_e = 1;
            if (trig >= 0) begin
                lo = (trig + 1 > DEPTH) ? trig + 1 - DEPTH : 0;
                for (int k = lo; k <= trig; k++) exp_q.push_back(vs[k]);
                if (post == 0) begin
                    complete = 1'b1;
                end else begin
                    st_e = 2;
                    n_left = post;
                    for (int k = trig + 1; k < vs.size() && !complete; k++) begin
                        if (exp_q.size() < DEPTH) begin
                            exp_q.push_back(vs[k]);
                            n_left--;
                            if (n_left == 0) complete = 1'b1;
                        end else begin
                            ovf_e = 1'b1;
                            complete = 1'b1;
                        end
                    end
                end
            end
            arm(lvl, rising, post);
            run(120, 2, 1'b0, 220);
            if (complete) begin
                cmp_words($sformatf("rand%0d_words", trial));
                chk($sformatf("rand%0d_done", trial), dones, 1);
                chk($sformatf("rand%0d_flags", trial), {ovf_seen, auto_seen}, {ovf_e, forced});
            end else begin
                @(negedge clk_i);
                chk($sformatf("rand%0d_wait_state", trial), bus.state_o, 2'(st_e));
                bus.abort_i = 1'b1;
                cyc();
                bus.abort_i = 1'b0;
                @(negedge clk_i);
                chk($sformatf("rand%0d_abort", trial), bus.state_o, 2'd0);
                cyc();
            end
            flush();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Acquisition sequencer for the oscilloscope sample FIFO (single clock domain, FIFO in first-word-fall-through mode).
- Keeps the FIFO as a pre-trigger ring while armed, detects a level/edge trigger, writes a programmed number of post-trigger samples, then drains the FIFO to a valid/ready output stream.
- Sits between the ADC sample stream, the FIFO write/read pointer controls, and the host readout path.

Parameters:
- DATA_WIDTH, 8, sample width in bits.
- ADDR_SIZE, 8, FIFO address width; FIFO depth is 2**ADDR_SIZE.
- AUTO_SAMPLES, 1024, valid samples in ARMED before a forced trigger (used only with the optional feature).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-low.
- arm_i  in  1  start acquisition; sampled in IDLE only.
- abort_i  in  1  return to IDLE; FIFO contents are not flushed.
- sample_i  in  DATA_WIDTH  ADC sample, unsigned.
- sample_vld_i  in  1  sample_i valid this cycle.
- trig_level_i  in  DATA_WIDTH  trigger threshold, unsigned.
- trig_rising_i  in  1  1 = rising edge, 0 = falling edge.
- post_cnt_i  in  ADDR_SIZE+1  post-trigger samples; latched at the trigger.
- fifo_full_i  in  1  FIFO full flag.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rdata_i  in  DATA_WIDTH  FIFO head word; valid while fifo_empty_i=0.
- fifo_wr_o  out  1  write-pointer increment.
- fifo_wdata_o  out  DATA_WIDTH  FIFO write data.
- fifo_rd_o  out  1  read-pointer increment.
- out_data_o  out  DATA_WIDTH  readout data.
- out_vld_o  out  1  readout valid.
- out_rdy_i  in  1  readout ready.
- state_o  out  2  IDLE=0, ARMED=1, POST=2, DRAIN=3.
- done_o  out  1  one-cycle pulse when the drain completes.
- ovf_o  out  1  sticky flag: a post-trigger sample was dropped because the FIFO was full.
- auto_trig_o  out  1  sticky flag: the last trigger was forced.

Behaviour:
- Reset values: state IDLE, all outputs 0, counters 0, prev_vld 0.
- fifo_wdata_o = sample_i (combinational).
- fifo_wr_o and fifo_rd_o are combinational in ARMED/POST/DRAIN as defined below, and 0 otherwise.
- abort_i has priority in every state: state <= IDLE next cycle; no wr/rd pulse that cycle; flags retained.

IDLE:
- arm_i=1 -> ARMED.
- Clears prev_vld, ovf_o, auto_trig_o and the auto counter.

ARMED (ring):
- Each sample_vld_i: fifo_wr_o=1.
- If fifo_full_i=1 in the same cycle, also fifo_rd_o=1 to drop the oldest word; the FIFO stays full.
- Trigger condition: prev_vld=1 and
  - rising: prev < trig_level_i and sample_i >= trig_level_i;
  - falling: prev > trig_level_i and sample_i <= trig_level_i.
- prev <= sample_i and prev_vld <= 1 on each valid sample.
- On trigger:
  - The triggering sample is written.
  - post counter <= post_cnt_i.
  - Next state POST, or DRAIN if post_cnt_i == 0.

POST:
- Each sample_vld_i with fifo_full_i=0: write the sample and decrement the counter. When the counter reaches 0 -> DRAIN.
- sample_vld_i with fifo_full_i=1: no write, ovf_o <= 1, -> DRAIN.
- No rd in POST.

DRAIN:
- out_vld_o = !fifo_empty_i.
- out_data_o = fifo_rdata_i.
- fifo_rd_o = out_vld_o & out_rdy_i.
- Samples arriving in DRAIN are ignored.
- fifo_empty_i=1 -> IDLE with done_o=1 for one cycle.
- out_vld_o is 0 in every other state.

Timing and boundary rules:
- Trigger detection to first POST write: next valid sample.
- Counter width ADDR_SIZE+1; post_cnt_i > depth is legal and ends by the overflow rule.
- arm_i asserted outside IDLE is ignored.

Optional Feature:
- Macro: CAPTURE_AUTO_TRIG_EN.
- With the macro: an ARMED-state counter increments on each valid sample. When it reaches AUTO_SAMPLES with no real trigger, a trigger is forced on that sample (same handling as a real trigger) and auto_trig_o <= 1. A real trigger on the same sample wins, and auto_trig_o stays 0.
- Without the macro: no counter is built, auto_trig_o is tied to 0, and ARMED waits indefinitely.

Test Plan:
- Reset mid-DRAIN (rst_i low 1 cycle) -> state_o=0, out_vld_o=0, done_o=0, ovf_o=0 immediately.
- ADDR_SIZE=4; arm; 40 ramp samples 0..39 below level 200 -> FIFO full after 16 samples, then wr+rd each sample; state stays ARMED.
- level=100, rising, post_cnt=3; samples 90, 110, 5, 6, 7:
  - trigger on 110, ARMED -> POST;
  - 5, 6, 7 written;
  - DRAIN outputs the ring contents ending ..., 90, 110, 5, 6, 7;
  - done_o pulses once.
- DRAIN with out_rdy_i toggling 1/0 -> fifo_rd_o only when ready; no word lost or duplicated; 16 words out.
- post_cnt=0 -> ARMED goes directly to DRAIN on the trigger sample.
- post_cnt=20 with depth 16 -> ovf_o=1 on the first full-drop.
- abort_i in POST -> IDLE next cycle.
- CAPTURE_AUTO_TRIG_EN, AUTO_SAMPLES=8, flat input 50 with level 100 -> forced trigger on the 8th sample, auto_trig_o=1.
